// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define SIGNED_DIV_EN to add the signed_op port and two's-complement sign correction.
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
`ifdef SIGNED_DIV_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q, r_rem, r_div;
  logic [WIDTH-1:0] r_quotient, r_remainder;
  logic             r_div_zero;

  logic             w_accept, w_zero, w_last;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_t, w_diff;
  logic             w_carry, w_unused_diff_msb;
  logic [WIDTH-1:0] w_q_next, w_rem_next, w_q_final, w_r_final;

  assign w_zero = (Divisor == '0);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_accept = 1'b1;
        w_next   = w_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = w_zero ? S_DONE : S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Trial subtraction as PartRem + ~Divisor + 1; carry-out means the divisor fits.
  assign w_t                              = {r_rem, r_q[WIDTH-1]};
  assign {w_carry, w_diff}                = {1'b0, w_t} + {1'b0, ~{1'b0, r_div}} + (WIDTH + 2)'(1);
  assign w_unused_diff_msb                = w_diff[WIDTH];
  assign w_rem_next                       = w_carry ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign w_q_next                         = {r_q[WIDTH-2:0], w_carry};

`ifdef SIGNED_DIV_EN
  logic w_a_neg, w_b_neg, r_neg_q, r_neg_r;
  assign w_a_neg   = signed_op & Dividend[WIDTH-1];
  assign w_b_neg   = signed_op & Divisor[WIDTH-1];
  assign w_a_mag   = w_a_neg ? -Dividend : Dividend;
  assign w_b_mag   = w_b_neg ? -Divisor  : Divisor;
  assign w_q_final = r_neg_q ? -w_q_next   : w_q_next;
  assign w_r_final = r_neg_r ? -w_rem_next : w_rem_next;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  assign w_a_mag   = Dividend;
  assign w_b_mag   = Divisor;
  assign w_q_final = w_q_next;
  assign w_r_final = w_rem_next;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt <= '0;
        if (w_zero) begin
          r_quotient  <= '1;
          r_remainder <= Dividend;
          r_div_zero  <= 1'b1;
        end
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_quotient  <= w_q_final;
          r_remainder <= w_r_final;
          r_div_zero  <= 1'b0;
        end
      end
    end
  end

  // NOTE: the working registers need no reset; they are always loaded on an accepted start before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_q   <= w_a_mag;
      r_div <= w_b_mag;
      r_rem <= '0;
    end else if (r_state == S_RUN) begin
      r_q   <= w_q_next;
      r_rem <= w_rem_next;
    end
  end

  assign Quotient  = r_quotient;
  assign Remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider32.sv
// Scoreboard bench for seq_divider32: expected results are queued at issue and compared at done.
// Signed cases run only when SIGNED_DIV_EN is defined.
module tb_seq_divider32;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
`ifdef SIGNED_DIV_EN
  logic         signed_op = 1'b0;
`endif
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  seq_divider32 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .Dividend  (dividend),
    .Divisor   (divisor),
`ifdef SIGNED_DIV_EN
    .signed_op (signed_op),
`endif
    .busy      (busy),
    .done      (done),
    .Quotient  (quotient),
    .Remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted start and queue its expected result from a reference model.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    logic [W-1:0] min_val;
    min_val = {1'b1, {(W-1){1'b0}}};
    e.dz = 1'b0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else if (s) begin
      if (a == min_val && b == '1) begin
        e.q = min_val;
        e.r = '0;
      end else begin
        e.q = W'($signed(a) / $signed(b));
        e.r = W'($signed(a) % $signed(b));
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    sb.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef SIGNED_DIV_EN
    signed_op = s;
`endif
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for done, check latency, then pop and compare the result.
  task automatic wait_result(input string name, input int exp_lat, output int busy_cycles);
    int   cyc;
    exp_t e;
    cyc = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) busy_cycles++;
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc, exp_lat);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue, want one entry", name);
    end else begin
      e = sb.pop_front();
      if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
        n_fail++;
        $display("FAIL %s result: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                 name, quotient, remainder, div_zero, e.q, e.r, e.dz);
      end
    end
  endtask

  task automatic test_reset;
    tick();
    tick();
    n_checks++;
    if ({busy, done, div_zero, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got busy=%b done=%b dz=%b q=%h r=%h, want all 0",
               busy, done, div_zero, quotient, remainder);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int bc;
    issue(32'd100, 32'd7, 1'b0);
    wait_result("100/7", 32, bc);
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_max_by_one;
    int bc;
    issue('1, 32'd1, 1'b0);
    wait_result("ffffffff/1", 32, bc);
    n_checks++;
    if (bc != 32) begin
      n_fail++;
      $display("FAIL busy_cycles: got %0d, want 32", bc);
    end
    tick();
  endtask

  task automatic test_div_zero;
    int bc;
    issue(32'd5, 32'd0, 1'b0);
    wait_result("5/0", 0, bc);
    n_checks++;
    if (bc != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL div0_busy: got %0d busy cycles busy=%b, want 0", bc, busy);
    end
    tick();
  endtask

  task automatic test_ignore_start;
    int bc;
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) tick();
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    tick();
    start = 1'b0;
    wait_result("ignored_start", 22, bc);
    issue(32'd9, 32'd3, 1'b0);
    wait_result("back_to_back 9/3", 32, bc);
    tick();
  endtask

  task automatic test_reset_abort;
    int dones;
    issue(32'd100, 32'd7, 1'b0);
    repeat (14) tick();
    n_checks++;
    if (quotient !== 32'd3 || remainder !== 32'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_in_run: got q=%h r=%h busy=%b, want q=3 r=0 busy=1",
               quotient, remainder, busy);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({busy, done, div_zero, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b done=%b dz=%b q=%h r=%h, want all 0",
               busy, done, div_zero, quotient, remainder);
    end
    rst_n = 1'b1;
    sb.delete();
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done pulses, want 0", dones);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a_tab[9];
    logic [W-1:0] b_tab[9];
    int bc;
    a_tab = '{32'd3, 32'd10, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
              $urandom(), $urandom(), $urandom(), $urandom()};
    b_tab = '{32'd10, 32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
              $urandom(), $urandom_range(255, 1), $urandom_range(65535, 2), 32'd0};
    for (int i = 0; i < 9; i++) begin
      issue(a_tab[i], b_tab[i], 1'b0);
      wait_result($sformatf("b2b[%0d] %h/%h", i, a_tab[i], b_tab[i]),
                  (b_tab[i] == '0) ? 0 : 32, bc);
    end
    tick();
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed;
    logic [W-1:0] a_tab[6];
    logic [W-1:0] b_tab[6];
    int bc;
    a_tab = '{-32'sd7, 32'h8000_0000, 32'd7, -32'sd8, -32'sd7, 32'h8000_0000};
    b_tab = '{32'd2, 32'hFFFF_FFFF, -32'sd2, -32'sd3, 32'd0, 32'd1};
    for (int i = 0; i < 6; i++) begin
      issue(a_tab[i], b_tab[i], 1'b1);
      wait_result($sformatf("signed[%0d] %h/%h", i, a_tab[i], b_tab[i]),
                  (b_tab[i] == '0) ? 0 : 32, bc);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_max_by_one();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
